// File: rtl/inc9_arb.sv
// Two-owner pointer block sharing one W-bit incrementer: round-robin grant between
// A and B, parallel loads per owner, and registered per-owner acknowledge and wrap flags.
module inc9_arb #(
    parameter int unsigned    W       = 9,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          sys_clk,
    input  logic          resetl,
    input  logic          ld_a,
    input  logic [W-1:0]  ld_val_a,
    input  logic          inc_req_a,
    input  logic          ld_b,
    input  logic [W-1:0]  ld_val_b,
    input  logic          inc_req_b,
    output logic [W-1:0]  ptr_a,
    output logic [W-1:0]  ptr_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          wrap_a,
    output logic          wrap_b
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    logic [W-1:0] ptr_a_q, ptr_a_d;
    logic [W-1:0] ptr_b_q, ptr_b_d;
    logic         ack_a_q, ack_b_q;
    logic         wrap_a_q, wrap_b_q;
    owner_e       last_gnt_q, last_gnt_d;

    logic         elig_a, elig_b;
    logic         gnt_a, gnt_b;
    logic [W-1:0] sel_ptr;
    logic [W-1:0] inc_out;
    logic         sel_all_ones;

    // A load on an owner removes it from arbitration, so the slot falls to the other owner.
    assign elig_a = inc_req_a & ~ld_a;
    assign elig_b = inc_req_b & ~ld_b;

    assign gnt_a = elig_a & (~elig_b | (last_gnt_q == OWN_B));
    assign gnt_b = elig_b & ~gnt_a;

    // The only adder in the block; its operand is steered by the grant.
    assign sel_ptr      = gnt_b ? ptr_b_q : ptr_a_q;
    assign inc_out      = sel_ptr + {{(W-1){1'b0}}, 1'b1};
    assign sel_all_ones = &sel_ptr;

    always_comb begin
        ptr_a_d    = ptr_a_q;
        ptr_b_d    = ptr_b_q;
        last_gnt_d = last_gnt_q;

        if (gnt_a) begin
            ptr_a_d    = inc_out;
            last_gnt_d = OWN_A;
        end else if (ld_a) begin
            ptr_a_d = ld_val_a;
        end

        if (gnt_b) begin
            ptr_b_d    = inc_out;
            last_gnt_d = OWN_B;
        end else if (ld_b) begin
            ptr_b_d = ld_val_b;
        end
    end

    // Reset leaves B as last winner so A takes the first contended slot.
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            ptr_a_q    <= RST_VAL;
            ptr_b_q    <= RST_VAL;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            wrap_a_q   <= 1'b0;
            wrap_b_q   <= 1'b0;
            last_gnt_q <= OWN_B;
        end else begin
            ptr_a_q    <= ptr_a_d;
            ptr_b_q    <= ptr_b_d;
            ack_a_q    <= gnt_a;
            ack_b_q    <= gnt_b;
            wrap_a_q   <= gnt_a & sel_all_ones;
            wrap_b_q   <= gnt_b & sel_all_ones;
            last_gnt_q <= last_gnt_d;
        end
    end

    assign ptr_a  = ptr_a_q;
    assign ptr_b  = ptr_b_q;
    assign ack_a  = ack_a_q;
    assign ack_b  = ack_b_q;
    assign wrap_a = wrap_a_q;
    assign wrap_b = wrap_b_q;

endmodule

// File: tb/tb_inc9_arb.sv
// Scoreboard bench for inc9_arb: stimulus pushes per-cycle expectations from a
// behavioural pointer model; a negedge monitor pops and compares them.
module tb_inc9_arb;

    localparam int W    = 9;
    localparam int MODV = 1 << W;

    logic         sys_clk = 1'b0;
    logic         resetl  = 1'b0;
    logic         ld_a = 1'b0, ld_b = 1'b0;
    logic [W-1:0] ld_val_a = '0, ld_val_b = '0;
    logic         inc_req_a = 1'b0, inc_req_b = 1'b0;
    logic [W-1:0] ptr_a, ptr_b;
    logic         ack_a, ack_b, wrap_a, wrap_b;

    inc9_arb #(.W(W), .RST_VAL('0)) dut (
        .sys_clk  (sys_clk),
        .resetl   (resetl),
        .ld_a     (ld_a),
        .ld_val_a (ld_val_a),
        .inc_req_a(inc_req_a),
        .ld_b     (ld_b),
        .ld_val_b (ld_val_b),
        .inc_req_b(inc_req_b),
        .ptr_a    (ptr_a),
        .ptr_b    (ptr_b),
        .ack_a    (ack_a),
        .ack_b    (ack_b),
        .wrap_a   (wrap_a),
        .wrap_b   (wrap_b)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int pa;
        int pb;
        bit aa;
        bit ab;
        bit wa;
        bit wb;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Model state: pointer values as integers and who won the most recent grant.
    int   m_pa, m_pb;
    bit   m_last_was_b;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every cycle the DUT presents a fresh set of registered outputs.
    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            txn++;
            $display("txn %0d cyc %0d: ptr_a=%03h ptr_b=%03h ack=%b%b wrap=%b%b (exp %03h %03h %b%b %b%b)",
                     txn, cyc, ptr_a, ptr_b, ack_a, ack_b, wrap_a, wrap_b,
                     e.pa[W-1:0], e.pb[W-1:0], e.aa, e.ab, e.wa, e.wb);
            chk("ptr_a",  int'(ptr_a),  e.pa);
            chk("ptr_b",  int'(ptr_b),  e.pb);
            chk("ack_a",  int'(ack_a),  int'(e.aa));
            chk("ack_b",  int'(ack_b),  int'(e.ab));
            chk("wrap_a", int'(wrap_a), int'(e.wa));
            chk("wrap_b", int'(wrap_b), int'(e.wb));
        end
    end

    task automatic model_reset();
        m_pa         = 0;
        m_pb         = 0;
        m_last_was_b = 1'b1;
    endtask

    // One clock of stimulus; the model decides the winner from the fairness rule.
    task automatic drive(input bit la, input int va, input bit ra,
                         input bit lb, input int vb, input bit rb);
        exp_t e;
        bit   want_a, want_b;
        int   winner;  // 0 none, 1 A, 2 B
        @(negedge sys_clk);
        ld_a = la; ld_val_a = va[W-1:0]; inc_req_a = ra;
        ld_b = lb; ld_val_b = vb[W-1:0]; inc_req_b = rb;

        want_a = ra && !la;
        want_b = rb && !lb;
        if (want_a && want_b)  winner = m_last_was_b ? 1 : 2;
        else if (want_a)       winner = 1;
        else if (want_b)       winner = 2;
        else                   winner = 0;

        e.aa = (winner == 1);
        e.ab = (winner == 2);
        e.wa = e.aa && (m_pa == MODV - 1);
        e.wb = e.ab && (m_pb == MODV - 1);
        if (e.aa)      m_pa = (m_pa + 1) % MODV;
        else if (la)   m_pa = va % MODV;
        if (e.ab)      m_pb = (m_pb + 1) % MODV;
        else if (lb)   m_pb = vb % MODV;
        if (winner == 1) m_last_was_b = 1'b0;
        if (winner == 2) m_last_was_b = 1'b1;
        e.pa  = m_pa;
        e.pb  = m_pb;
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(negedge sys_clk);
        #2 resetl = 1'b0;
        #1;
        chk("rst_ptr_a",  int'(ptr_a),  0);
        chk("rst_ptr_b",  int'(ptr_b),  0);
        chk("rst_ack_a",  int'(ack_a),  0);
        chk("rst_ack_b",  int'(ack_b),  0);
        chk("rst_wrap_a", int'(wrap_a), 0);
        chk("rst_wrap_b", int'(wrap_b), 0);
        sb.delete();
        model_reset();
        ld_a = 1'b0; ld_b = 1'b0; inc_req_a = 1'b0; inc_req_b = 1'b0;
        @(negedge sys_clk);
        resetl = 1'b1;
    endtask

    initial begin
        int bound;
        model_reset();
        #12;
        chk("init_ptr_a", int'(ptr_a), 0);
        chk("init_ack_a", int'(ack_a), 0);
        @(negedge sys_clk);
        resetl = 1'b1;

        // Contention straight out of reset: A first.
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Solo burst from zero.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Contention with distinct bases.
        drive(1, 'h010, 0, 1, 'h100, 0);
        for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Wrap on B, then the increment after the wrap.
        drive(0, 0, 0, 1, 'h1FF, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 'h1FF, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);

        // Load beats increment on A; B takes the slot.
        drive(1, 'h0AA, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);

        // Dual load, no requests, then a contention to expose last winner.
        drive(1, 'h155, 0, 1, 'h0F0, 0);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);

        // Reset mid-burst, then contention again: A first.
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 1);
        async_reset();
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);

        // Randomised traffic, with loads near the wrap point to exercise wrap.
        for (int i = 0; i < 400; i++) begin
            bit la, lb, ra, rb;
            int va, vb;
            la = ($urandom_range(0, 7) == 0);
            lb = ($urandom_range(0, 7) == 0);
            ra = ($urandom_range(0, 3) != 0);
            rb = ($urandom_range(0, 3) != 0);
            va = ($urandom_range(0, 1) != 0) ? int'($urandom_range(MODV - 3, MODV - 1))
                                             : int'($urandom_range(0, MODV - 1));
            vb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(MODV - 3, MODV - 1))
                                             : int'($urandom_range(0, MODV - 1));
            drive(la, va, ra, lb, vb, rb);
            if (i == 200) async_reset();
        end
        drive(0, 0, 0, 0, 0, 0);

        bound = 0;
        while (sb.size() > 0 && bound < 20) begin
            @(negedge sys_clk);
            bound++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
